// File: rtl/mandelbrot_dispatch.sv
// rtl/mandelbrot_dispatch.sv - frame controller feeding coordinates to round-robin Mandelbrot engines
module mandelbrot_dispatch #(
    parameter int NE  = 4,
    parameter int AW  = 12,
    parameter int FPW = 27,
    parameter int FCW = 16
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    output logic [FCW-1:0]   frame_cnt,
    output logic             err,
    output logic             coord_init,
    input  logic             coord_done,
    input  logic             coord_vld,
    output logic             coord_rdy,
    input  logic [FPW-1:0]   coord_x,
    input  logic [FPW-1:0]   coord_y,
    input  logic [AW-1:0]    coord_adr,
    output logic [NE-1:0]    eng_start,
    output logic [FPW-1:0]   eng_x,
    output logic [FPW-1:0]   eng_y,
    output logic [AW-1:0]    eng_adr,
    input  logic [NE-1:0]    eng_done
);

    // Pointer width; a single engine still gets a one-bit pointer that stays at 0.
    localparam int PW  = (NE > 1) ? $clog2(NE) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [PW1-1:0] NE_W   = PW1'(NE);
    localparam logic [PW1-1:0] LAST_W = PW1'(NE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state;
    logic           first_run;
    logic [NE-1:0]  pend;
    logic [PW-1:0]  ptr;

    logic [PW1-1:0] cand_w;
    logic [PW-1:0]  cand;
    logic [PW-1:0]  sel_idx;
    logic           sel_ok;
    logic [NE-1:0]  sel_oh;
    logic [PW-1:0]  ptr_next;
    logic           accept;
    logic [NE-1:0]  done_bad;

    assign busy      = (state != S_IDLE);
    assign coord_rdy = (state == S_RUN) && !(&pend);
    assign accept    = coord_vld && coord_rdy && sel_ok;
    assign done_bad  = eng_done & ~pend;
    assign sel_oh    = NE'(1) << sel_idx;

    // Round-robin search: first free engine starting at ptr, wrapping at NE.
    always_comb begin
        sel_ok  = 1'b0;
        sel_idx = '0;
        cand_w  = '0;
        cand    = '0;
        for (int k = 0; k < NE; k++) begin
            cand_w = {1'b0, ptr} + PW1'(k);
            if (cand_w >= NE_W) begin
                cand_w = cand_w - NE_W;
            end
            cand = cand_w[PW-1:0];
            if (!sel_ok && !pend[cand]) begin
                sel_ok  = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Pointer advances past the chosen engine, wrapping explicitly for non-power-of-2 NE.
    always_comb begin
        ptr_next = '0;
        if ({1'b0, sel_idx} != LAST_W) begin
            ptr_next = sel_idx + 1'b1;
        end
    end

    // Frame sequencing: init pulse, streaming, drain until engines idle, completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            first_run  <= 1'b0;
            coord_init <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else if (clk_en) begin
            coord_init <= 1'b0;
            frame_done <= 1'b0;
            first_run  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_INIT;
                        coord_init <= 1'b1;
                    end
                end
                S_INIT: begin
                    state     <= S_RUN;
                    first_run <= 1'b1;
                end
                S_RUN: begin
                    // coord_done may still be stale from the previous frame in the first RUN cycle.
                    if (!first_run && coord_done && !coord_vld) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pend == '0) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Dispatch: register the accepted point onto the shared bus and pulse the chosen engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            eng_adr   <= '0;
            ptr       <= '0;
        end else if (clk_en) begin
            eng_start <= accept ? sel_oh : '0;
            if (accept) begin
                eng_x   <= coord_x;
                eng_y   <= coord_y;
                eng_adr <= coord_adr;
                ptr     <= ptr_next;
            end
        end
    end

    // Pending tracking: completions clear, dispatch sets; a completion for an idle engine is an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            err  <= 1'b0;
        end else if (clk_en) begin
            pend <= (pend & ~eng_done) | (accept ? sel_oh : '0);
            if (|done_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_dispatch.sv
// tb/tb_mandelbrot_dispatch.sv - randomized bench for mandelbrot_dispatch with behavioural model
module tb_mandelbrot_dispatch;
    localparam int NE = 4, AW = 12, FPW = 27, FCW = 16;

    logic clk = 1'b0;
    logic clk_en, rst, start, coord_done, coord_vld;
    logic [FPW-1:0] coord_x, coord_y;
    logic [AW-1:0] coord_adr;
    logic [NE-1:0] eng_done;
    logic busy, frame_done, err, coord_init, coord_rdy;
    logic [FCW-1:0] frame_cnt;
    logic [NE-1:0] eng_start;
    logic [FPW-1:0] eng_x, eng_y;
    logic [AW-1:0] eng_adr;

    mandelbrot_dispatch #(.NE(NE), .AW(AW), .FPW(FPW), .FCW(FCW)) dut (
        .clk(clk), .clk_en(clk_en), .rst(rst), .start(start), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err), .coord_init(coord_init),
        .coord_done(coord_done), .coord_vld(coord_vld), .coord_rdy(coord_rdy),
        .coord_x(coord_x), .coord_y(coord_y), .coord_adr(coord_adr),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_adr(eng_adr),
        .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    bit cmp_en = 0;

    // model: phase 0 idle, 1 init, 2 run, 3 drain, 4 done
    int m_state, m_ptr, m_start, m_cnt;
    bit m_first, m_err, m_acc;
    bit m_pend[NE];
    logic [FPW-1:0] m_x, m_y;
    logic [AW-1:0] m_adr;

    // stimulus state
    bit hold_rst, trig_rst, start_req, en_rand, gap_rand, froze, did_rst, fr_started;
    bit loaded, frame_armed, done_flag;
    int frame_n, fdelay, pts_left, next_adr, acc_cnt, freeze_left, freeze_after, rst_after;
    int timer[NE];
    bit done_q[NE];
    logic [NE-1:0] inj;
    int fd_seen;
    int rec_idx[$], rec_adr[$];
    logic [NE-1:0] exp_es;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit all_pend();
        bit a = 1;
        for (int i = 0; i < NE; i++) a &= m_pend[i];
        return a;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_start = -1; m_cnt = 0; m_first = 0; m_err = 0;
        m_x = '0; m_y = '0; m_adr = '0;
        for (int i = 0; i < NE; i++) m_pend[i] = 0;
    endtask

    // one enabled clock of the specified behaviour, from the inputs as sampled
    task automatic model_step();
        bit old[NE];
        bit acc, none;
        int sel;
        m_acc = 0;
        if (rst) begin
            model_reset();
        end else if (clk_en) begin
            none = 1;
            for (int i = 0; i < NE; i++) begin old[i] = m_pend[i]; if (old[i]) none = 0; end
            acc = coord_vld && m_state == 2 && !all_pend();
            sel = -1;
            for (int k = 0; k < NE; k++)
                if (sel < 0 && !old[(m_ptr + k) % NE]) sel = (m_ptr + k) % NE;
            for (int i = 0; i < NE; i++)
                if (eng_done[i]) begin
                    if (old[i]) m_pend[i] = 0; else m_err = 1;
                end
            if (acc) begin
                m_start = sel; m_x = coord_x; m_y = coord_y; m_adr = coord_adr;
                m_pend[sel] = 1; m_ptr = (sel + 1) % NE; m_acc = 1;
            end else m_start = -1;
            case (m_state)
                0: if (start) m_state = 1;
                1: begin m_state = 2; m_first = 1; end
                2: begin
                    if (!m_first && coord_done && !coord_vld) m_state = 3;
                    m_first = 0;
                end
                3: if (none) begin m_state = 4; m_cnt = (m_cnt + 1) % 65536; end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic cycle();
        bit rst_now, en_now;
        @(posedge clk);
        model_step();
        #2;
        rst_now = rst;
        en_now = clk_en;
        if (m_state != 0) begin start_req = 0; fr_started = 1; end
        if (m_acc) begin acc_cnt++; pts_left--; next_adr++; end
        // engine emulation: done held until an enabled edge consumes it
        for (int i = 0; i < NE; i++) begin
            if (rst_now) begin timer[i] = -1; done_q[i] = 0; end
            else begin
                if (eng_done[i] && en_now) done_q[i] = 0;
                if (en_now && m_start == i) timer[i] = (fdelay > 0) ? fdelay : $urandom_range(1, 12);
                else if (timer[i] > 0) begin
                    timer[i]--;
                    if (timer[i] == 0) begin done_q[i] = 1; timer[i] = -1; end
                end
            end
        end
        // coordinate generator
        if (rst_now) begin loaded = 0; pts_left = 0; done_flag = 0; frame_armed = 0; end
        if (frame_armed && !loaded && m_state == 2 && !m_first) begin
            loaded = 1; pts_left = frame_n; next_adr = 0; done_flag = 0;
        end
        if (loaded && pts_left == 0) done_flag = 1;
        if (rst_now) coord_vld = 0;
        else if (coord_vld && !m_acc) ;
        else if (loaded && pts_left > 0 && (!gap_rand || $urandom_range(0, 2) != 0)) begin
            coord_vld = 1; coord_x = FPW'($urandom); coord_y = FPW'($urandom); coord_adr = AW'(next_adr);
        end else coord_vld = 0;
        coord_done = done_flag;
        // directed events
        if (freeze_after >= 0 && !froze && acc_cnt == freeze_after && m_state == 2) begin
            freeze_left = 10; froze = 1;
        end
        trig_rst = 0;
        if (rst_after >= 0 && !did_rst && acc_cnt == rst_after && m_state == 2) begin
            trig_rst = 1; did_rst = 1;
        end
        rst = hold_rst | trig_rst;
        start = start_req | (m_state != 0 && $urandom_range(0, 3) == 0);
        if (rst) clk_en = 1;
        else if (freeze_left > 0) begin clk_en = 0; freeze_left--; end
        else clk_en = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
        for (int i = 0; i < NE; i++) eng_done[i] = done_q[i];
        eng_done = eng_done | inj;
    endtask

    task automatic run_frame(input int n, input int d, input int fz, input int ra);
        int cyc = 0;
        frame_n = n; fdelay = d; freeze_after = fz; rst_after = ra;
        froze = 0; did_rst = 0; fr_started = 0; loaded = 0; frame_armed = 1; acc_cnt = 0;
        start_req = 1;
        while (cyc < 3000 && !(fr_started && m_state == 0)) begin
            cycle();
            cyc++;
        end
        if (cyc >= 3000) check("frame_timeout", 1, 0);
        freeze_after = -1; rst_after = -1;
    endtask

    // compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_es = (m_start >= 0) ? (NE'(1) << m_start) : '0;
            check("busy", 64'(busy), 64'(m_state != 0));
            check("coord_init", 64'(coord_init), 64'(m_state == 1));
            check("frame_done", 64'(frame_done), 64'(m_state == 4));
            check("coord_rdy", 64'(coord_rdy), 64'(m_state == 2 && !all_pend()));
            check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
            check("err", 64'(err), 64'(m_err));
            check("eng_start", 64'(eng_start), 64'(exp_es));
            check("eng_x", 64'(eng_x), 64'(m_x));
            check("eng_y", 64'(eng_y), 64'(m_y));
            check("eng_adr", 64'(eng_adr), 64'(m_adr));
            for (int i = 0; i < NE; i++)
                if (eng_start[i]) begin rec_idx.push_back(i); rec_adr.push_back(int'(eng_adr)); end
            if (frame_done) fd_seen++;
        end
    end

    initial begin
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1; clk_en = 1; start = 0; coord_done = 0; coord_vld = 0;
        coord_x = '0; coord_y = '0; coord_adr = '0; eng_done = '0; inj = '0;
        model_reset();
        for (int i = 0; i < NE; i++) begin timer[i] = -1; done_q[i] = 0; end
        hold_rst = 1; freeze_after = -1; rst_after = -1; fdelay = 5;
        cycle();
        cmp_en = 1;
        repeat (2) cycle();
        hold_rst = 0;
        cycle();
        @(negedge clk); #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_frame_cnt", 64'(frame_cnt), 0);
        check("rst_eng_start", 64'(eng_start), 0);
        check("rst_eng_x", 64'(eng_x), 0);

        // 4x2 frame, engines finish 5 cycles after start, no stalls
        en_rand = 0; gap_rand = 0; fd_seen = 0;
        rec_idx.delete(); rec_adr.delete();
        run_frame(8, 5, -1, -1);
        @(negedge clk); #1;
        check("f1_ndisp", 64'(rec_idx.size()), 8);
        for (int i = 0; i < 8 && i < rec_idx.size(); i++) begin
            check("f1_order", 64'(rec_idx[i]), 64'(exp_order[i]));
            check("f1_adr", 64'(rec_adr[i]), 64'(i));
        end
        check("f1_frame_done", 64'(fd_seen), 1);
        check("f1_frame_cnt", 64'(frame_cnt), 1);

        // randomized frames with stalls, a clock-enable freeze and a mid-frame reset
        en_rand = 1; gap_rand = 1;
        for (int f = 0; f < 25; f++) begin
            run_frame($urandom_range(1, 20), (f % 3 == 0) ? 0 : $urandom_range(1, 15),
                      (f == 4) ? 2 : -1, (f == 8) ? 3 : -1);
            if (f == 8) begin
                @(negedge clk); #1;
                check("rst_mid_busy", 64'(busy), 0);
                check("rst_mid_rdy", 64'(coord_rdy), 0);
                check("rst_mid_fdone", 64'(frame_done), 0);
            end
        end

        // completion from an engine that has nothing pending
        en_rand = 0;
        repeat (2) cycle();
        inj = 4'b0010;
        cycle();
        inj = '0;
        cycle();
        @(negedge clk); #1;
        check("err_set", 64'(err), 1);
        check("err_busy", 64'(busy), 0);
        repeat (3) cycle();
        @(negedge clk); #1;
        check("err_sticky", 64'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
